// File: rtl/mux16_rr_sched_pkg.sv
// mux16_sched_pkg: shared constants, FSM states and the round-robin pick function
package mux16_sched_pkg;
    localparam int N = 16;
    localparam int SELW = 4;

    typedef enum logic {IDLE, GRANT} state_e;

    // Returns {found, index} of the first set request at or after start, wrapping mod N
    function automatic logic [SELW:0] rr_pick(input logic [N-1:0] req, input logic [SELW-1:0] start);
        logic [N-1:0] rot;
        logic [SELW-1:0] idx;
        logic found;
        rot = (req >> start) | (req << (N - int'(start)));
        idx = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                idx = SELW'(i);
                found = 1'b1;
            end
        end
        return {found, idx + start};
    endfunction
endpackage

// File: rtl/mux16_rr_sched_pick16.sv
// rr_pick16: combinational rotate / priority-encode / rotate-back request search
module rr_pick16
    import mux16_sched_pkg::*;
(
    input  logic [N-1:0]    req_i,
    input  logic [SELW-1:0] start_i,
    output logic            found_o,
    output logic [SELW-1:0] idx_o
);
    assign {found_o, idx_o} = rr_pick(req_i, start_i);
endmodule

// File: rtl/mux16_rr_sched.sv
// mux16_rr_sched: round-robin owner of a 16:1 bit mux select with hold limit and registered data
module mux16_rr_sched
    import mux16_sched_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_i,
    input  logic [N-1:0]    din_i,
    output logic [SELW-1:0] sel_o,
    output logic [N-1:0]    gnt_o,
    output logic            busy_o,
    output logic            dout_o,
    output logic            dout_valid_o
);
    localparam int HW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;

    state_e          state_q, state_d;
    logic [SELW-1:0] sel_q, sel_d, ptr_q, ptr_d, start, pick_idx;
    logic [HW-1:0]   hold_q, hold_d;
    logic            pick_found, rel, expire, dout_q, dv_q;

    // A finishing grant searches from the slot after the holder, so the holder is considered last
    assign start  = state_q == GRANT ? sel_q + SELW'(1) : ptr_q;
    assign rel    = !req_i[sel_q];
    assign expire = hold_q == HW'(MAX_HOLD - 1);

    rr_pick16 u_pick (
        .req_i   (req_i),
        .start_i (start),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // State register: FSM state, select, search pointer and hold counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    // Next state: grant from idle, extend, or hand over directly at release/expiry
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        if (state_q == IDLE) begin
            state_d = pick_found ? GRANT : IDLE;
            sel_d   = pick_found ? pick_idx : sel_q;
            hold_d  = '0;
        end else if (!rel && !expire) begin
            hold_d  = hold_q + HW'(1);
        end else begin
            ptr_d   = start;
            state_d = pick_found ? GRANT : IDLE;
            sel_d   = pick_found ? pick_idx : sel_q;
            hold_d  = '0;
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        busy_o       = state_q == GRANT;
        sel_o        = sel_q;
        gnt_o        = busy_o ? N'(1) << sel_q : '0;
        dout_o       = dout_q;
        dout_valid_o = dv_q;
    end

    // Data register: capture the muxed bit while granted, otherwise hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_q <= 1'b0;
            dv_q   <= 1'b0;
        end else begin
            dv_q   <= state_q == GRANT;
            dout_q <= state_q == GRANT ? din_i[sel_q] : dout_q;
        end
    end
endmodule

// File: tb/tb_mux16_rr_sched.sv
// tb_mux16_rr_sched: table vectors, directed sequences and random stimulus against a reference model
module tb_mux16_rr_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] req = '0;
    logic [15:0] din = '0;
    logic [3:0]  sel8, sel2;
    logic [15:0] gnt8, gnt2;
    logic        busy8, busy2, dout8, dout2, dv8, dv2;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    mux16_rr_sched #(.MAX_HOLD(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .req_i(req), .din_i(din),
        .sel_o(sel8), .gnt_o(gnt8), .busy_o(busy8), .dout_o(dout8), .dout_valid_o(dv8)
    );

    mux16_rr_sched #(.MAX_HOLD(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_i(req), .din_i(din),
        .sel_o(sel2), .gnt_o(gnt2), .busy_o(busy2), .dout_o(dout2), .dout_valid_o(dv2)
    );

    typedef struct {
        int own;
        int ptr;
        int cnt;
        int sel;
        bit dout;
        bit dv;
    } mdl_t;

    typedef struct {
        logic        rn;
        logic [15:0] req;
        logic [15:0] din;
        logic [3:0]  sel;
        logic [15:0] gnt;
        logic        busy;
        logic        dout;
        logic        dv;
    } vec_t;

    mdl_t m8 = '{-1, 0, 0, 0, 1'b0, 1'b0};
    mdl_t m2 = '{-1, 0, 0, 0, 1'b0, 1'b0};
    vec_t tbl [19];

    function automatic mdl_t step(mdl_t m, int mh, logic [15:0] r, logic [15:0] d, logic rn);
        mdl_t n;
        int start;
        n = m;
        if (!rn) begin
            n = '{-1, 0, 0, 0, 1'b0, 1'b0};
            return n;
        end
        n.dv = m.own >= 0;
        if (m.own >= 0) n.dout = d[m.own];
        if (m.own >= 0 && r[m.own] && m.cnt < mh - 1) begin
            n.cnt = m.cnt + 1;
        end else begin
            start = m.own >= 0 ? (m.own + 1) % 16 : m.ptr;
            if (m.own >= 0) n.ptr = start;
            n.own = -1;
            for (int k = 0; k < 16; k++)
                if (n.own < 0 && r[(start + k) % 16]) n.own = (start + k) % 16;
            n.cnt = 0;
            if (n.own >= 0) n.sel = n.own;
        end
        return n;
    endfunction

    function automatic logic [22:0] pk(mdl_t m);
        return {4'(m.sel), m.own >= 0 ? 16'(1) << m.own : 16'h0, m.own >= 0, m.dout, m.dv};
    endfunction

    task automatic chk(input string nm, input logic [22:0] got, input logic [22:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (sel,gnt,busy,dout,dv)", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m8 = step(m8, 8, req, din, rst_n);
        m2 = step(m2, 2, req, din, rst_n);
        #1;
        chk("model_h8", {sel8, gnt8, busy8, dout8, dv8}, pk(m8));
        chk("model_h2", {sel2, gnt2, busy2, dout2, dv2}, pk(m2));
    endtask

    initial begin
        tbl[0]  = '{1'b0, 16'hFFFF, 16'h0000, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 16'hFFFF, 16'h0000, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 16'hFFFF, 16'h0000, 4'd0,  16'h0001, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 16'h0000, 16'hFFFF, 4'd0,  16'h0000, 1'b0, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 16'h0020, 16'h0020, 4'd5,  16'h0020, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 16'h0020, 16'h0000, 4'd5,  16'h0020, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 16'h0020, 16'h0020, 4'd5,  16'h0020, 1'b1, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 16'h0000, 16'h0000, 4'd5,  16'h0000, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 16'h0000, 16'hFFFF, 4'd5,  16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 16'h8000, 16'h0000, 4'd15, 16'h8000, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 16'h0003, 16'h8000, 4'd0,  16'h0001, 1'b1, 1'b1, 1'b1};
        tbl[11] = '{1'b1, 16'h0000, 16'h0000, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 16'h0080, 16'h0000, 4'd7,  16'h0080, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 16'h0080, 16'h0000, 4'd7,  16'h0080, 1'b1, 1'b0, 1'b1};
        tbl[14] = '{1'b1, 16'h0080, 16'h0000, 4'd7,  16'h0080, 1'b1, 1'b0, 1'b1};
        tbl[15] = '{1'b1, 16'h0080, 16'h0080, 4'd7,  16'h0080, 1'b1, 1'b1, 1'b1};
        tbl[16] = '{1'b0, 16'h0080, 16'h0000, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 16'h0084, 16'h0000, 4'd2,  16'h0004, 1'b1, 1'b0, 1'b0};
        tbl[18] = '{1'b1, 16'h0000, 16'h0004, 4'd2,  16'h0000, 1'b0, 1'b1, 1'b1};

        for (int i = 0; i < 19; i++) begin
            rst_n = tbl[i].rn;
            req   = tbl[i].req;
            din   = tbl[i].din;
            tick();
            chk($sformatf("table_row%0d", i), {sel8, gnt8, busy8, dout8, dv8},
                {tbl[i].sel, tbl[i].gnt, tbl[i].busy, tbl[i].dout, tbl[i].dv});
        end

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req   = 16'h8101;
        for (int i = 0; i < 12; i++) begin
            int ord [3] = '{0, 8, 15};
            din = 16'($urandom);
            tick();
            chk($sformatf("rr_order_c%0d", i), {3'b000, busy2, sel2}, {3'b000, 1'b1, 4'(ord[(i / 2) % 3])});
        end

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req   = 16'h0400;
        for (int i = 0; i < 20; i++) begin
            din = 16'($urandom);
            tick();
            chk($sformatf("sole_expiry_c%0d", i), {3'b000, busy8, sel8}, {3'b000, 1'b1, 4'd10});
        end

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0)
                req = $urandom_range(0, 1) != 0 ? 16'($urandom) : 16'($urandom & $urandom & $urandom);
            din   = 16'($urandom);
            rst_n = $urandom_range(0, 59) != 0;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mux16_rr_sched.md
# mux16_rr_sched

Round-robin scheduler that shares a 16:1 single-bit mux among 16 requesters. It arbitrates a 16-bit request vector, drives the mux 4-bit select, and holds each grant until release or a hold limit. It registers the selected data bit with a valid flag. It sits in front of the existing 4:1-tree 16:1 mux and owns its select line exclusively.

## Interface
- MAX_HOLD, 8: maximum consecutive cycles one grant may last (≥1)
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req  in  16  request per source; bit i = source i
- din  in  16  data bits to the mux; bit i = source i
- sel  out  4  mux select = index of granted source
- gnt  out  16  one-hot grant, all-zero when idle
- busy  out  1  a grant is active
- dout  out  1  registered din[sel]
- dout_valid  out  1  dout holds data from a granted cycle

## Operation
- States: IDLE, GRANT. Internal ptr (4b) is the search start; hold_cnt counts from 0 to MAX_HOLD-1.
- Pick function: first i with req[i]=1, searching ptr, ptr+1, … ptr+15, mod 16.
- IDLE: if req≠0, load sel=pick(ptr), gnt=1<<pick, busy=1, hold_cnt=0, go GRANT. Else stay; sel holds its last value.
- GRANT, continue: if req[sel]=1 and hold_cnt<MAX_HOLD-1, keep the grant and increment hold_cnt.
- GRANT, end: a grant ends when req[sel]=0 (release) or hold_cnt=MAX_HOLD-1 (expiry).
  - Set ptr=sel+1 mod 16.
  - Re-pick in the same cycle from sel+1. The current holder is eligible only after all others, so it is regranted only if it is the sole requester.
  - If a winner exists, switch directly to it with no idle gap and hold_cnt=0.
  - If none, go IDLE: gnt=0, busy=0.
- Release and expiry in the same cycle: treated as a release.
- Requests dropping while not granted are ignored; there is no request latching.
- Data path: every cycle, dout<=din[sel] when busy=1, else dout holds. dout_valid<=busy.
- Reset: when rst_n=0 at a clock edge, return to IDLE regardless of state.
  - Outputs: sel=0, gnt=0, busy=0, dout=0, dout_valid=0.
  - Internal: ptr=0, hold_cnt=0.
  - An in-flight grant is dropped without a release.

## Timing
- All outputs are registered; no combinational path from req/din to any output.
- Request to grant: req rises before edge k, so gnt/sel/busy are valid after edge k (1 cycle).
- Grant to data: dout/dout_valid reflect din[sel] after edge k+1 (2 cycles from request).
- Switch latency: release sampled at edge m, so the new gnt is valid after edge m. The old grant's last dout appears after edge m.
- A grant lasts 1..MAX_HOLD cycles. Worst-case wait for any requester is 15×MAX_HOLD cycles.
- gnt is always one-hot or zero. gnt≠0 iff busy=1. When busy=1, gnt=1<<sel.

## Structure
- Package mux16_sched_pkg:
  - constants N=16, SELW=4
  - state enum {IDLE, GRANT}
  - function rr_pick(req, start) returning {found, index}
- Sub-module: rr_pick16, the combinational rotate/priority-encode/rotate-back search.
- Instantiate the existing 16:1 mux on din/sel for the dout path. The scheduler adds only the output register.

## Test plan
- Reset: drive rst_n=0 for 2 cycles with req=16'hFFFF. Required: sel=0, gnt=0, busy=0, dout_valid=0 throughout. First grant after release is source 0.
- Single requester: req=16'h0020 for 3 cycles, then 0. Required: gnt=16'h0020 and sel=5 for 3 cycles, then busy=0. dout tracks din[5] one cycle later. dout_valid is high for 3 cycles.
- Round-robin: req=16'h8101 held constant, MAX_HOLD=2. Required: grant order 0,8,15,0,8,… with each grant exactly 2 cycles and no idle gaps.
- Wrap and pointer: grant source 15, release, then req=16'h0003. Required: next grant is source 0 (ptr wrapped to 0), not source 1.
- Sole requester expiry: req=16'h0400 held for 20 cycles, MAX_HOLD=8. Required: sel=10 continuously and busy never drops. hold_cnt restarts at cycles 8 and 16.
- Reset mid-grant: sel=7 with hold_cnt=3, assert rst_n=0 for 1 cycle. Required: all outputs reset on that edge. After reset, with req=16'h0080|16'h0004, source 2 wins because ptr=0.
